// File: rtl/ycbcr_quant_sequencer.sv
// ycbcr_quant_sequencer: runs one converted RGB block per enabled channel through the shared DCT and quantizer and emits tagged beats.
// Optional perf_blocks/perf_stall counters are enabled by defining QSEQ_PERF_CNT_EN.
module ycbcr_quant_sequencer #(
  parameter int NUM_CH = 3,
  parameter int PIXEL_COUNT = 64,
  parameter int FP_W = 32,
  parameter int Q_W = 8,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            blk_valid,
  output logic                            blk_ready,
  input  logic [NUM_CH-1:0]               blk_chan_mask,
  output logic                            cvt_start,
  input  logic                            cvt_done,
  input  logic [NUM_CH*PIXEL_COUNT*FP_W-1:0] cvt_data,
  output logic                            dct_in_valid,
  input  logic                            dct_in_ready,
  output logic [PIXEL_COUNT*FP_W-1:0]     dct_in_data,
  input  logic                            dct_out_valid,
  output logic                            dct_out_ready,
  output logic                            q_start,
  output logic                            q_luma_sel,
  input  logic                            q_done,
  input  logic [PIXEL_COUNT*Q_W-1:0]      q_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PIXEL_COUNT*Q_W-1:0]      out_data,
  output logic [CH_W-1:0]                 out_chan,
  output logic                            out_last
`ifdef QSEQ_PERF_CNT_EN
  ,
  output logic [31:0]                     perf_blocks,
  output logic [31:0]                     perf_stall
`endif
);
  localparam int BLK_W = PIXEL_COUNT*FP_W;
  localparam int QB_W = PIXEL_COUNT*Q_W;
  localparam logic [2:0] IDLE = 3'd0, CONVERT = 3'd1, DCT_SEND = 3'd2, DCT_WAIT = 3'd3, QUANT = 3'd4, Q_HOLD = 3'd5;
  logic [2:0] state_q, state_d;
  logic [NUM_CH-1:0] mask_q, hi_mask;
  logic [CH_W-1:0] ch_q, ch_d, first_ch, next_ch, out_chan_q;
  logic [NUM_CH*BLK_W-1:0] buf_q;
  logic [QB_W-1:0] out_data_q;
  logic cvt_start_q, out_valid_q, out_last_q, ld, last, blk_hs;
  assign blk_ready = state_q == IDLE && !out_valid_q;
  assign blk_hs = blk_valid && blk_ready;
  assign cvt_start = cvt_start_q;
  assign dct_in_valid = state_q == DCT_SEND;
  assign dct_in_data = dct_in_valid ? buf_q[ch_q*BLK_W +: BLK_W] : '0;
  assign dct_out_ready = state_q == DCT_WAIT;
  assign q_start = dct_out_ready && dct_out_valid;
  assign q_luma_sel = (state_q == DCT_WAIT || state_q == QUANT || state_q == Q_HOLD) && ch_q == '0;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_chan = out_chan_q;
  assign out_last = out_last_q;
  always_comb begin
    hi_mask = '0;
    first_ch = '0;
    next_ch = '0;
    for (int i = 0; i < NUM_CH; i++) hi_mask[i] = mask_q[i] && (i > int'(ch_q));
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (mask_q[i]) first_ch = CH_W'(i);
      if (hi_mask[i]) next_ch = CH_W'(i);
    end
    last = ~|hi_mask;
    // q_data stays stable until the next q_start, so Q_HOLD reads it directly instead of buffering it
    ld = (state_q == QUANT && q_done && (!out_valid_q || out_ready)) || (state_q == Q_HOLD && out_ready);
    state_d = state_q;
    ch_d = ch_q;
    case (state_q)
      IDLE:     state_d = (blk_hs && |blk_chan_mask) ? CONVERT : IDLE;
      CONVERT:  if (cvt_done) begin
        state_d = DCT_SEND;
        ch_d = first_ch;
      end
      DCT_SEND: state_d = dct_in_ready ? DCT_WAIT : DCT_SEND;
      DCT_WAIT: state_d = dct_out_valid ? QUANT : DCT_WAIT;
      QUANT:    state_d = q_done ? Q_HOLD : QUANT;
      Q_HOLD:   state_d = Q_HOLD;
      default:  state_d = IDLE;
    endcase
    if (ld) begin
      state_d = last ? IDLE : DCT_SEND;
      ch_d = last ? ch_q : next_ch;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q <= '0;
      ch_q <= '0;
      cvt_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      cvt_start_q <= blk_hs && |blk_chan_mask;
      if (blk_hs) mask_q <= blk_chan_mask;
      if (ld) begin
        out_valid_q <= 1'b1;
        out_data_q <= q_data;
        out_chan_q <= ch_q;
        out_last_q <= last;
      end else if (out_ready) out_valid_q <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == CONVERT && cvt_done) buf_q <= cvt_data;
  end
`ifdef QSEQ_PERF_CNT_EN
  logic [31:0] perf_blocks_q, perf_stall_q;
  assign perf_blocks = perf_blocks_q;
  assign perf_stall = perf_stall_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_blocks_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (out_valid_q && out_ready && out_last_q) perf_blocks_q <= perf_blocks_q + 32'd1;
      if (out_valid_q && !out_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ycbcr_quant_sequencer.sv
// tb_ycbcr_quant_sequencer: stub engines plus a queue-based reference model of the expected channel sequence.
module tb_ycbcr_quant_sequencer;
  localparam int NC = 3, PC = 64, FW = 32, QW = 8, CW = 2;
  localparam int BW = PC*FW, QB = PC*QW;
  typedef struct { logic [QB-1:0] d; logic [CW-1:0] c; logic l; } beat_t;
  logic clk = 0, rst = 1, blk_valid = 0, blk_ready, cvt_start, cvt_done = 0;
  logic [NC-1:0] blk_chan_mask = '0;
  logic [NC*BW-1:0] cvt_data = '0;
  logic dct_in_valid, dct_in_ready = 0, dct_out_valid = 0, dct_out_ready;
  logic [BW-1:0] dct_in_data, dct_last = '0, q_in = '0;
  logic q_start, q_luma_sel, q_done = 0, out_valid, out_ready = 1, out_last;
  logic [QB-1:0] q_data = '0, out_data;
  logic [CW-1:0] out_chan;
`ifdef QSEQ_PERF_CNT_EN
  logic [31:0] perf_blocks, perf_stall;
`endif
  int n_checks = 0, n_fail = 0;
  int n_cvt = 0, n_qs = 0, n_qd = 0, n_beats = 0, n_ov = 0;
  int cvt_cnt = 0, dct_cnt = 0, q_cnt = 0;
  bit stub_clr = 0;
  beat_t exp_beats[$];
  int exp_dct[$], exp_q[$];
  always #5 clk = ~clk;
  ycbcr_quant_sequencer dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_chan_mask(blk_chan_mask),
    .cvt_start(cvt_start), .cvt_done(cvt_done), .cvt_data(cvt_data),
    .dct_in_valid(dct_in_valid), .dct_in_ready(dct_in_ready), .dct_in_data(dct_in_data),
    .dct_out_valid(dct_out_valid), .dct_out_ready(dct_out_ready),
    .q_start(q_start), .q_luma_sel(q_luma_sel), .q_done(q_done), .q_data(q_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan), .out_last(out_last)
`ifdef QSEQ_PERF_CNT_EN
    , .perf_blocks(perf_blocks), .perf_stall(perf_stall)
`endif
  );
  function automatic logic [QB-1:0] qfun(input logic [BW-1:0] d);
    logic [QB-1:0] r;
    for (int i = 0; i < PC; i++) r[i*QW +: QW] = d[i*FW +: 8] + 8'(i);
    return r;
  endfunction
  // stub engines: converter 4 cycles, DCT 10 cycles, quantizer 3 cycles
  always @(posedge clk) begin
    cvt_done <= 0;
    if (cvt_start) cvt_cnt <= 4;
    else if (cvt_cnt > 0) begin
      cvt_cnt <= cvt_cnt - 1;
      if (cvt_cnt == 1) cvt_done <= 1;
    end
  end
  always @(posedge clk) begin
    dct_in_ready <= 1'($urandom_range(0, 1));
    if (stub_clr) begin
      dct_cnt <= 0;
      dct_out_valid <= 0;
    end else begin
      if (dct_out_valid && dct_out_ready) dct_out_valid <= 0;
      if (dct_in_valid && dct_in_ready) begin
        dct_cnt <= 10;
        dct_last <= dct_in_data;
      end else if (dct_cnt > 0) begin
        dct_cnt <= dct_cnt - 1;
        if (dct_cnt == 1) dct_out_valid <= 1;
      end
    end
  end
  always @(posedge clk) begin
    q_done <= 0;
    if (q_start) begin
      q_cnt <= 3;
      q_in <= dct_last;
    end else if (q_cnt > 0) begin
      q_cnt <= q_cnt - 1;
      if (q_cnt == 1) begin
        q_done <= 1;
        q_data <= qfun(q_in);
      end
    end
  end
  // monitors
  bit st_pend = 0, din_pend = 0, lat_pend = 0;
  logic [QB+CW:0] out_snap;
  logic [BW-1:0] din_snap;
  always @(negedge clk) begin
    if (rst) begin
      st_pend = 0; din_pend = 0; lat_pend = 0;
    end else begin
      if (cvt_start) n_cvt++;
      if (q_done) n_qd++;
      if (out_valid) n_ov++;
      if (st_pend) begin
        n_checks++;
        if ({out_valid, out_data, out_chan, out_last} !== {1'b1, out_snap}) begin
          n_fail++;
          $display("FAIL out_hold: got valid=%b chan=%0d last=%b, required held beat chan=%0d last=%b", out_valid, out_chan, out_last, out_snap[CW:1], out_snap[0]);
        end
      end
      st_pend = out_valid && !out_ready;
      out_snap = {out_data, out_chan, out_last};
      if (din_pend) begin
        n_checks++;
        if (!dct_in_valid || dct_in_data !== din_snap) begin
          n_fail++;
          $display("FAIL dct_in_hold: valid=%b data changed while not accepted", dct_in_valid);
        end
      end
      din_pend = dct_in_valid && !dct_in_ready;
      din_snap = dct_in_data;
      if (lat_pend) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL q_done_latency: out_valid=%b, required 1", out_valid);
        end
      end
      lat_pend = q_done && (!out_valid || out_ready);
      if (dct_in_valid && dct_in_ready) begin
        n_checks++;
        if (exp_dct.size() == 0) begin
          n_fail++;
          $display("FAIL dct_send: unexpected send, none required");
        end else begin
          int c;
          c = exp_dct.pop_front();
          if (dct_in_data !== cvt_data[c*BW +: BW]) begin
            n_fail++;
            $display("FAIL dct_send: data low word %h, required slice %0d low word %h", dct_in_data[31:0], c, cvt_data[c*BW +: 32]);
          end
        end
      end
      if (q_start) begin
        n_qs++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL q_start: unexpected pulse, none required");
        end else begin
          int c;
          c = exp_q.pop_front();
          if (q_luma_sel !== (c == 0)) begin
            n_fail++;
            $display("FAIL q_luma_sel: got %b for chan %0d, required %b", q_luma_sel, c, c == 0);
          end
        end
      end
      if (out_valid && out_ready) begin
        n_beats++;
        n_checks++;
        if (exp_beats.size() == 0) begin
          n_fail++;
          $display("FAIL out_beat: unexpected beat chan=%0d", out_chan);
        end else begin
          beat_t b;
          b = exp_beats.pop_front();
          if (out_data !== b.d || out_chan !== b.c || out_last !== b.l) begin
            n_fail++;
            $display("FAIL out_beat: got chan=%0d last=%b data[31:0]=%h, required chan=%0d last=%b data[31:0]=%h", out_chan, out_last, out_data[31:0], b.c, b.l, b.d[31:0]);
          end
        end
      end
    end
  end
  task automatic do_req(input logic [NC-1:0] m);
    bit got;
    int hi;
    @(posedge clk) #1;
    for (int i = 0; i < NC*BW/32; i++) cvt_data[i*32 +: 32] = $urandom;
    hi = -1;
    for (int c = 0; c < NC; c++) if (m[c]) hi = c;
    for (int c = 0; c < NC; c++) if (m[c]) begin
      exp_dct.push_back(c);
      exp_q.push_back(c);
      exp_beats.push_back('{qfun(cvt_data[c*BW +: BW]), CW'(c), c == hi});
    end
    blk_valid = 1;
    blk_chan_mask = m;
    got = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      got = blk_ready;
    end
    @(posedge clk) #1;
    blk_valid = 0;
    @(negedge clk);
    n_checks++;
    if (!got || cvt_start !== (m != 0)) begin
      n_fail++;
      $display("FAIL cvt_start: handshake=%b cvt_start=%b, required %b", got, cvt_start, m != 0);
    end
  endtask
  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = blk_ready && exp_beats.size() == 0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_done: timeout, %0d beats still required", exp_beats.size());
    end
  endtask
  task automatic apply_reset();
    @(posedge clk) #1;
    rst = 1;
    @(posedge clk) #1;
    rst = 0;
    exp_beats.delete();
    exp_dct.delete();
    exp_q.delete();
  endtask
  task automatic check_idle_outputs(input string nm);
    n_checks++;
    if ({cvt_start, dct_in_valid, dct_in_data != 0, dct_out_ready, q_start, q_luma_sel, out_valid, out_data != 0, out_chan, out_last, blk_ready} !== {12'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL %s: outputs cvt=%b din=%b dor=%b qs=%b luma=%b ov=%b chan=%0d last=%b rdy=%b, required all 0 and blk_ready=1", nm, cvt_start, dct_in_valid, dct_out_ready, q_start, q_luma_sel, out_valid, out_chan, out_last, blk_ready);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_idle_outputs("reset_state");
  endtask
  task automatic test_all_channels();
    n_beats = 0;
    do_req(3'b111);
    wait_done();
    n_checks++;
    if (n_beats !== 3) begin
      n_fail++;
      $display("FAIL all_channels_count: got %0d beats, required 3", n_beats);
    end
  endtask
  task automatic test_skip_channel();
    n_beats = 0;
    do_req(3'b101);
    wait_done();
    n_checks++;
    if (n_beats !== 2) begin
      n_fail++;
      $display("FAIL skip_count: got %0d beats, required 2", n_beats);
    end
  endtask
  task automatic test_backpressure();
    int qs0, qd0;
    bit seen;
    n_beats = 0;
    qs0 = n_qs;
    qd0 = n_qd;
    out_ready = 0;
    do_req(3'b111);
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (!seen || n_qs - qs0 !== 2 || n_qd - qd0 !== 2 || n_beats !== 0) begin
      n_fail++;
      $display("FAIL backpressure: valid_seen=%b q_starts=%0d q_dones=%0d beats=%0d, required 1 2 2 0", seen, n_qs - qs0, n_qd - qd0, n_beats);
    end
    @(posedge clk) #1;
    out_ready = 1;
    wait_done();
    n_checks++;
    if (n_beats !== 3) begin
      n_fail++;
      $display("FAIL backpressure_count: got %0d beats, required 3", n_beats);
    end
  endtask
  task automatic test_zero_mask();
    int c0, o0;
    c0 = n_cvt;
    o0 = n_ov;
    do_req(3'b000);
    repeat (20) @(negedge clk);
    n_checks++;
    if (n_cvt !== c0 || n_ov !== o0 || blk_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_mask: cvt_starts=%0d out_valid_cycles=%0d blk_ready=%b, required 0 0 1", n_cvt - c0, n_ov - o0, blk_ready);
    end
    n_beats = 0;
    do_req(3'b001);
    wait_done();
    n_checks++;
    if (n_beats !== 1) begin
      n_fail++;
      $display("FAIL zero_mask_followup: got %0d beats, required 1", n_beats);
    end
  endtask
  task automatic test_reset_mid();
    bit inw, late;
    int qs0;
    do_req(3'b111);
    inw = 0;
    for (int i = 0; i < 500 && !inw; i++) begin
      @(negedge clk);
      inw = dct_out_ready && !dct_out_valid && dct_cnt > 3;
    end
    apply_reset();
    qs0 = n_qs;
    late = 0;
    repeat (20) begin
      @(negedge clk);
      late |= dct_out_valid;
    end
    n_checks++;
    if (!inw || !late || n_qs !== qs0) begin
      n_fail++;
      $display("FAIL reset_mid: reached_wait=%b late_valid=%b q_starts=%0d, required 1 1 0", inw, late, n_qs - qs0);
    end
    check_idle_outputs("reset_mid_outputs");
    @(posedge clk) #1 stub_clr = 1;
    @(posedge clk) #1 stub_clr = 0;
    n_beats = 0;
    do_req(3'b011);
    wait_done();
    n_checks++;
    if (n_beats !== 2) begin
      n_fail++;
      $display("FAIL reset_mid_followup: got %0d beats, required 2", n_beats);
    end
  endtask
  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      logic [NC-1:0] m;
      m = NC'($urandom_range(1, 7));
      out_ready = 1'($urandom_range(0, 1));
      do_req(m);
      repeat ($urandom_range(0, 30)) @(negedge clk);
      @(posedge clk) #1 out_ready = 1;
      wait_done();
    end
  endtask
`ifdef QSEQ_PERF_CNT_EN
  task automatic test_perf();
    bit seen;
    apply_reset();
    out_ready = 1;
    do_req(3'b111);
    wait_done();
    out_ready = 0;
    do_req(3'b111);
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    repeat (4) @(posedge clk);
    @(posedge clk) #1 out_ready = 1;
    wait_done();
    n_checks++;
    if (perf_blocks !== 32'd2 || perf_stall !== 32'd5) begin
      n_fail++;
      $display("FAIL perf: blocks=%0d stall=%0d, required 2 5", perf_blocks, perf_stall);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_all_channels();
    test_skip_channel();
    test_backpressure();
    test_zero_mask();
    test_reset_mid();
    test_back_to_back();
`ifdef QSEQ_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ycbcr_quant_sequencer.md
Name: ycbcr_quant_sequencer

Overview:
- Multi-channel controller for the colour-convert -> DCT -> quantize path.
- Accepts one RGB block request, triggers the converter once, and captures every component.
- Streams the enabled components (Y, Cb, Cr, or any subset) one at a time through the shared DCT and quantizer. Channel 0 uses the luma table; all other channels use the chroma table.
- Emits tagged quantized blocks over a valid/ready output. The next channel's DCT overlaps with output backpressure.

Parameters:
- NUM_CH, 3, number of components produced by the converter (1..4)
- PIXEL_COUNT, 64, coefficients per block
- FP_W, 32, fixed-point width of converter and DCT words
- Q_W, 8, width of one quantized coefficient
- CH_W, $clog2(NUM_CH) (minimum 1), width of the channel tag

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- blk_valid  in  1  block request valid
- blk_ready  out  1  sequencer can accept a request
- blk_chan_mask  in  NUM_CH  channels to emit, sampled on handshake
- cvt_start  out  1  one-cycle converter start pulse
- cvt_done  in  1  converter result valid, one-cycle pulse
- cvt_data  in  NUM_CH*PIXEL_COUNT*FP_W  all components; channel c occupies slice c*PIXEL_COUNT*FP_W
- dct_in_valid  out  1  DCT input valid
- dct_in_ready  in  1  DCT input ready
- dct_in_data  out  PIXEL_COUNT*FP_W  selected component
- dct_out_valid  in  1  DCT result valid
- dct_out_ready  out  1  DCT result accepted
- q_start  out  1  one-cycle quantizer start pulse
- q_luma_sel  out  1  1 = luma table, 0 = chroma table; stable from q_start until q_done
- q_done  in  1  quantizer done pulse; q_data is stable from q_done until the next q_start
- q_data  in  PIXEL_COUNT*Q_W  quantized coefficients
- out_valid  out  1  output block valid
- out_ready  in  1  downstream ready
- out_data  out  PIXEL_COUNT*Q_W  quantized block
- out_chan  out  CH_W  channel index of out_data
- out_last  out  1  final enabled channel of the current request

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, mask register cleared, output register empty.
  - All outputs 0, except blk_ready=1 one cycle after rst deasserts.
  - Reset mid-operation abandons the block; any late cvt_done, dct_out_valid or q_done arriving while in IDLE is ignored.
- States: IDLE, CONVERT, DCT_SEND, DCT_WAIT, QUANT, Q_HOLD.
- IDLE:
  - blk_ready=1 only when the output register is empty.
  - Handshake with mask!=0: latch the mask, pulse cvt_start the next cycle, go to CONVERT.
  - Handshake with mask==0: request consumed; no cvt_start, no output; remain in IDLE.
- CONVERT:
  - On cvt_done, capture cvt_data into the component buffer (NUM_CH*PIXEL_COUNT*FP_W flops).
  - ch = lowest set mask bit; go to DCT_SEND.
- DCT_SEND:
  - dct_in_valid=1 with dct_in_data = buffer slice ch.
  - Hold data stable until dct_in_ready, then go to DCT_WAIT.
- DCT_WAIT:
  - dct_out_ready=1.
  - On dct_out_valid: pulse q_start in the same cycle; q_luma_sel=(ch==0); go to QUANT.
- QUANT, on q_done:
  - If the output register is empty, or it is being drained this cycle (out_valid&&out_ready): load q_data, ch and last into the output register.
  - Otherwise go to Q_HOLD, and load in the first cycle the register frees.
- After the load:
  - If a higher enabled channel remains: ch = next set bit, go to DCT_SEND, overlapping with the pending output.
  - Otherwise go to IDLE.
- Output register:
  - out_valid stays high until out_ready.
  - out_data, out_chan and out_last hold stable while out_valid && !out_ready.
  - At most one quantized block is held beyond the output register, in Q_HOLD.
- out_last=1 only on the highest set mask bit. Channels are always emitted in ascending index order.
- Latency from blk handshake to cvt_start: 1 cycle. Latency from q_done to out_valid: 1 cycle when the output register is free.
- blk_valid while busy: blk_ready=0, so the request waits.
- Counter and tag widths are sized so that NUM_CH=1 works (CH_W=1, out_chan always 0).

Optional Feature:
- Macro QSEQ_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_blocks[31:0] (count of completed requests, incremented when the out_last beat handshakes).
  - Adds perf_stall[31:0] (count of cycles with out_valid && !out_ready).
  - Both counters wrap at 2^32, clear on rst, and are readable at any time.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Stub engines (converter 4 cycles, DCT 10 cycles, quantizer 3 cycles), mask=3'b111, out_ready=1 -> three beats, out_chan 0,1,2; q_luma_sel 1,0,0; out_last only on chan 2; blk_ready returns to 1 after the last beat.
- mask=3'b101 -> exactly two beats, chan 0 then chan 2 (out_last=1); dct_in_data on the second send equals converter slice 2.
- out_ready=0 for 40 cycles during mask=3'b111 -> first beat held bit-stable; exactly one further q_done absorbed in Q_HOLD; no third q_start until the first beat drains; all three beats delivered in order.
- mask=3'b000 with blk_valid=1 -> no cvt_start, no out_valid; the following request with mask=3'b001 runs normally.
- rst=1 for 1 cycle while in DCT_WAIT, then a late dct_out_valid arrives -> it is ignored, no q_start, all outputs 0, blk_ready=1.
- With QSEQ_PERF_CNT_EN defined: two mask=3'b111 requests and 5 stall cycles -> perf_blocks=2, perf_stall=5.
